// File: rtl/tratador_botao.sv
// rtl/tratador_botao.sv - push-button debouncer and press-duration classifier
module tratador_botao #(
    parameter int DEBOUNCE_P        = 300,
    parameter int SWITCH_MODE_MIN_T = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic push_button,
    output logic pressionado,
    output logic A,
    output logic B,
    output logic longo
);

    localparam int TD_W = $clog2(DEBOUNCE_P + 1);
    localparam int TP_W = $clog2(SWITCH_MODE_MIN_T + 1);

    localparam logic [TD_W-1:0] TD_ONE  = TD_W'(1);
    localparam logic [TD_W-1:0] TD_LAST = TD_W'(DEBOUNCE_P - 1);
    localparam logic [TP_W-1:0] TP_MAX  = TP_W'(SWITCH_MODE_MIN_T);
    localparam logic [TP_W-1:0] TP_PRE  = TP_W'(SWITCH_MODE_MIN_T - 1);

    typedef enum logic [1:0] {
        INICIAL,
        FILTRO_PRESS,
        CONTANDO,
        FILTRO_SOLTA
    } estado_t;

    estado_t         state_q, state_d;
    logic [TD_W-1:0] td_q, td_d;
    logic [TP_W-1:0] tp_q, tp_d;
    logic            pres_q, pres_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            longo_q, longo_d;

    logic [TP_W-1:0] tp_sat;
    logic            tp_hit;

    assign tp_sat = (tp_q == TP_MAX) ? tp_q : tp_q + TP_W'(1);
    assign tp_hit = (tp_q == TP_PRE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= INICIAL;
            td_q    <= '0;
            tp_q    <= '0;
            pres_q  <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            longo_q <= 1'b0;
        end else begin
            state_q <= state_d;
            td_q    <= td_d;
            tp_q    <= tp_d;
            pres_q  <= pres_d;
            a_q     <= a_d;
            b_q     <= b_d;
            longo_q <= longo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        td_d    = td_q;
        tp_d    = tp_q;
        pres_d  = pres_q;
        a_d     = 1'b0;
        b_d     = 1'b0;
        longo_d = longo_q;

        case (state_q)
            INICIAL: begin
                td_d = '0;
                tp_d = '0;
                if (push_button) begin
                    state_d = FILTRO_PRESS;
                    td_d    = TD_ONE;
                end
            end

            FILTRO_PRESS: begin
                if (!push_button) begin
                    state_d = INICIAL;
                    td_d    = '0;
                end else if (td_q == TD_LAST) begin
                    state_d = CONTANDO;
                    pres_d  = 1'b1;
                    td_d    = '0;
                    tp_d    = '0;
                end else begin
                    td_d = td_q + TD_W'(1);
                end
            end

            CONTANDO: begin
                tp_d = tp_sat;
                if (tp_hit) begin
                    a_d     = 1'b1;
                    longo_d = 1'b1;
                end
                if (!push_button) begin
                    state_d = FILTRO_SOLTA;
                    td_d    = TD_ONE;
                end
            end

            FILTRO_SOLTA: begin
                // Accepted release takes priority: a press released exactly at the threshold is short.
                if (!push_button && td_q == TD_LAST) begin
                    state_d = INICIAL;
                    pres_d  = 1'b0;
                    td_d    = '0;
                    tp_d    = '0;
                    b_d     = !longo_q;
                    longo_d = 1'b0;
                end else begin
                    tp_d = tp_sat;
                    if (tp_hit) begin
                        a_d     = 1'b1;
                        longo_d = 1'b1;
                    end
                    if (push_button) begin
                        state_d = CONTANDO;
                        td_d    = '0;
                    end else begin
                        td_d = td_q + TD_W'(1);
                    end
                end
            end

            default: begin
                state_d = INICIAL;
                td_d    = '0;
                tp_d    = '0;
            end
        endcase
    end

    assign pressionado = pres_q;
    assign A           = a_q;
    assign B           = b_q;
    assign longo       = longo_q;

endmodule

// File: tb/tb_tratador_botao.sv
// tb/tb_tratador_botao.sv - directed self-checking bench for tratador_botao
module tb_tratador_botao;

    logic clk;
    logic rst;
    logic push_button;
    logic pressionado;
    logic A;
    logic B;
    logic longo;

    int checks;
    int failures;

    tratador_botao #(
        .DEBOUNCE_P       (4),
        .SWITCH_MODE_MIN_T(20)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_button(push_button),
        .pressionado(pressionado),
        .A          (A),
        .B          (B),
        .longo      (longo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Outputs are packed as {pressionado, A, B, longo} in every comparison.
    task automatic drive(input logic b, input logic r);
        push_button = b;
        rst         = r;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [3:0] exp;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, 1'b1);
            exp = 4'b0000;
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL reset_hold step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
        for (int i = 1; i <= 6; i++) begin
            drive(1'b0, 1'b0);
            exp = 4'b0000;
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL reset_idle step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] exp;
        for (int i = 1; i <= 8; i++) begin
            drive(i <= 3, 1'b0);
            exp = 4'b0000;
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL bounce step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
    endtask

    task automatic test_short_press();
        logic [3:0] exp;
        for (int i = 1; i <= 10; i++) begin
            drive(1'b1, 1'b0);
            exp = {i >= 4, 1'b0, 1'b0, 1'b0};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL short_hold step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
        for (int j = 1; j <= 6; j++) begin
            drive(1'b0, 1'b0);
            exp = {j < 4, 1'b0, j == 4, 1'b0};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL short_release step=%0d got=%b exp=%b", j, {pressionado, A, B, longo}, exp);
            end
        end
    endtask

    task automatic test_long_press();
        logic [3:0] exp;
        for (int i = 1; i <= 40; i++) begin
            drive(1'b1, 1'b0);
            exp = {i >= 4, i == 24, 1'b0, i >= 24};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL long_hold step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
        for (int j = 1; j <= 6; j++) begin
            drive(1'b0, 1'b0);
            exp = {j < 4, 1'b0, 1'b0, j < 4};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL long_release step=%0d got=%b exp=%b", j, {pressionado, A, B, longo}, exp);
            end
        end
    endtask

    task automatic test_release_glitch();
        logic [3:0] exp;
        for (int i = 1; i <= 30; i++) begin
            drive(!(i == 11 || i == 12), 1'b0);
            exp = {i >= 4, i == 24, 1'b0, i >= 24};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL glitch_hold step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
        for (int j = 1; j <= 6; j++) begin
            drive(1'b0, 1'b0);
            exp = {j < 4, 1'b0, 1'b0, j < 4};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL glitch_release step=%0d got=%b exp=%b", j, {pressionado, A, B, longo}, exp);
            end
        end
    endtask

    task automatic test_threshold_release();
        logic [3:0] exp;
        for (int i = 1; i <= 27; i++) begin
            drive(i <= 20, 1'b0);
            exp = {i >= 4 && i < 24, 1'b0, i == 24, 1'b0};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL threshold step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
    endtask

    task automatic test_reset_mid_press();
        logic [3:0] exp;
        for (int i = 1; i <= 23; i++) begin
            drive(1'b1, 1'b0);
            exp = {i >= 4, 1'b0, 1'b0, 1'b0};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL midrst_hold step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
        for (int i = 1; i <= 7; i++) begin
            drive(i == 1, i <= 2);
            exp = 4'b0000;
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL midrst_after step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
        for (int i = 1; i <= 9; i++) begin
            drive(i <= 4, 1'b0);
            exp = {i >= 4 && i < 8, 1'b0, i == 8, 1'b0};
            checks++;
            if ({pressionado, A, B, longo} !== exp) begin
                failures++;
                $display("FAIL midrst_repress step=%0d got=%b exp=%b", i, {pressionado, A, B, longo}, exp);
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        push_button = 1'b0;
        test_reset();
        test_bounce();
        test_short_press();
        test_long_press();
        test_release_glitch();
        test_threshold_release();
        test_reset_mid_press();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tratador_botao.md
Name: tratador_botao

Overview:
- Push-button front end of the controladora. Debounces `push_button` and measures how long it is held.
- Emits one-cycle command pulses: A (long press, switch mode) and B (short press, toggle).
- Sits directly upstream of the mode/LED logic and the auto-shutdown stage (INICIAL/CONTANDO/TEMP). Its pulses feed that stage's mode select and `enable` generation.

Parameters:
- DEBOUNCE_P, 300: consecutive identical samples needed to accept a press or a release. Legal range >= 2.
- SWITCH_MODE_MIN_T, 5000: held cycles, counted from press acceptance, that classify a press as long. Legal range >= 1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge
- rst  in  1  synchronous, active-high reset
- push_button  in  1  raw button level, 1 = pressed, already synchronised to clk
- pressionado  out  1  debounced button level
- A  out  1  one-cycle pulse: long press reached SWITCH_MODE_MIN_T
- B  out  1  one-cycle pulse: short press released
- longo  out  1  high from A until the release is accepted

Behaviour:
- All outputs are registered.
- Reset: state=INICIAL, Td=0, Tp=0, pressionado=0, A=0, B=0, longo=0. Reset wins over every other event, including a pulse that would fire on the same edge; that pulse is dropped.
- Counters:
  - Td counts debounce samples, width $clog2(DEBOUNCE_P+1).
  - Tp counts hold cycles, width $clog2(SWITCH_MODE_MIN_T+1), saturates at SWITCH_MODE_MIN_T (no wrap).
- INICIAL: Td=0, Tp=0. Sample push_button=1 -> FILTRO_PRESS with Td=1.
- FILTRO_PRESS:
  - Sample 1 with Td < DEBOUNCE_P-1 -> Td+1.
  - Sample 1 with Td = DEBOUNCE_P-1 -> CONTANDO, pressionado=1, Tp=0. CONTANDO is entered on the DEBOUNCE_P-th consecutive high sample.
  - Sample 0 -> INICIAL, Td=0, no pulse (bounce rejected).
- CONTANDO:
  - Tp increments every edge.
  - On the edge where Tp goes SWITCH_MODE_MIN_T-1 -> SWITCH_MODE_MIN_T: A=1 for exactly that cycle, longo=1.
  - Sample 0 -> FILTRO_SOLTA with Td=1.
- FILTRO_SOLTA:
  - Tp keeps counting, and A may still fire here. Glitches therefore do not restart the hold time.
  - Sample 1 -> CONTANDO, Td=0.
  - Sample 0 with Td < DEBOUNCE_P-1 -> Td+1.
  - Sample 0 with Td = DEBOUNCE_P-1 -> INICIAL, pressionado=0, Tp=0. On that same edge: if longo=0 then B=1 for one cycle; longo clears.
- At most one of A or B fires per press, and never both in the same cycle.
- A fires once per press; it does not repeat while held.
- Boundary: a release accepted on the very edge where Tp would reach SWITCH_MODE_MIN_T counts as short → B fires, A does not.
- Button held forever: A once, then Tp stays saturated and outputs are idle until release.
- Latency:
  - pressionado rises DEBOUNCE_P-1 edges after the first high sample is taken.
  - A fires SWITCH_MODE_MIN_T edges after pressionado rises.
  - B fires on the edge that accepts the release.

Test Plan (bench uses DEBOUNCE_P=4, SWITCH_MODE_MIN_T=20):
- rst=1 for 5 cycles with push_button=1, then rst=0 and button held 0 -> state INICIAL, all outputs 0, no pulse.
- Bounce: button 1 for 3 cycles, then 0 -> returns to INICIAL; pressionado, A and B stay 0.
- Short press: button 1 for 10 cycles, then 0 -> pressionado=1 after 4th high sample; B=1 for one cycle on 4th low sample; A never 1.
- Long press: button 1 for 40 cycles -> A=1 for exactly one cycle, 20 edges after pressionado rises; longo=1; release gives B=0, longo=0.
- Release glitch: held, then 0 for 2 cycles, back to 1, total held >= 24 -> no B during glitch; A fires at the uninterrupted Tp timing.
- Reset mid-press (Tp=19) -> outputs 0 next edge; no A ever; new press starts cleanly.
